flash_stream_reader: RTL

FLASH_STREAM_READER -- requirements
Module: flash_stream_reader

---
 rtl/flash_pkg.sv | 14 +
 rtl/sync_fifo.sv | 53 +++++
 rtl/flash_stream_reader.sv | 133 +++++++++++++
 3 files changed

// File: rtl/flash_pkg.sv
// Shared definitions for the flash streaming reader: data word width and
// the fetch FSM encodings.
package flash_pkg;

   localparam int WORD_W = 16;

   typedef logic [WORD_W-1:0] word_t;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_HOLD  = 2'd3;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock prefetch FIFO with registered pointers and an occupancy count.
// The read data is the current head; there is no write-to-read bypass.
module sync_fifo
   import flash_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int LW    = $clog2(DEPTH) + 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              clear,
   input  logic              wr_en,
   input  logic [WORD_W-1:0] wr_data,
   input  logic              rd_en,
   output logic [WORD_W-1:0] rd_data,
   output logic [LW-1:0]     level
);

   localparam int PW = $clog2(DEPTH);

   word_t         mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;

   assign rd_data = mem[rd_ptr];

   // NOTE: storage is deliberately not reset; the pointers and level decide what is valid.
   always_ff @(posedge clock) begin
      if (wr_en) mem[wr_ptr] <= wr_data;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + PW'(1);
         if (rd_en) rd_ptr <= rd_ptr + PW'(1);
         case ({wr_en, rd_en})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/flash_stream_reader.sv
// Streams an inclusive flash word range into a prefetch FIFO, one read at a
// time, and hands words out on demand through a registered sample port.
module flash_stream_reader
   import flash_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int AW    = 23
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   stop,
   input  logic                   loop,
   input  logic [AW-1:0]          start_addr,
   input  logic [AW-1:0]          end_addr,
   output logic                   fm_doread,
   output logic [AW-1:0]          fm_raddr,
   input  logic                   fm_busy,
   input  logic [WORD_W-1:0]      fm_rdata,
   input  logic                   sample_req,
   output logic [WORD_W-1:0]      sample,
   output logic                   sample_valid,
   output logic                   underflow,
   output logic                   done,
   output logic [$clog2(DEPTH):0] level
);

   localparam int LW = $clog2(DEPTH) + 1;
   localparam logic [LW-1:0] FULL = LW'(DEPTH);

   logic [1:0]    state;
   logic [AW-1:0] addr;
   logic [AW-1:0] start_lat;
   logic [AW-1:0] end_lat;
   logic          loop_lat;

   logic          go;
   logic          wr_fire;
   logic          pop_ok;
   logic [LW-1:0] lvl_after;
   word_t         head;

   assign fm_doread = (state == ST_ISSUE);
   assign fm_raddr  = addr;

   always_comb begin
      // NOTE: every output gets a default first so no path leaves a latch behind.
      go        = 1'b0;
      wr_fire   = 1'b0;
      pop_ok    = 1'b0;
      lvl_after = level;
      if (state == ST_IDLE && start && !stop && !fm_busy) go = 1'b1;
      if (state == ST_WAIT && !fm_busy && !stop) wr_fire = 1'b1;
      // A start clears the FIFO, so it swallows a pop requested in the same cycle.
      if (sample_req && level != '0 && !go) pop_ok = 1'b1;
      if (!pop_ok) lvl_after = level + LW'(1);
   end

   sync_fifo #(
      .DEPTH (DEPTH),
      .LW    (LW)
   ) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .clear   (go),
      .wr_en   (wr_fire),
      .wr_data (fm_rdata),
      .rd_en   (pop_ok),
      .rd_data (head),
      .level   (level)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         addr      <= '0;
         start_lat <= '0;
         end_lat   <= '0;
         loop_lat  <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         if (stop) begin
            state <= ST_IDLE;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (go) begin
                     start_lat <= start_addr;
                     end_lat   <= end_addr;
                     loop_lat  <= loop;
                     addr      <= start_addr;
                     state     <= ST_ISSUE;
                  end
               end
               ST_ISSUE: begin
                  if (fm_busy) state <= ST_WAIT;
               end
               ST_WAIT: begin
                  if (wr_fire) begin
                     if (addr == end_lat && !loop_lat) begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                     end else begin
                        addr  <= (addr == end_lat) ? start_lat : addr + AW'(1);
                        // A new read is launched only if its word is guaranteed a slot.
                        state <= (lvl_after < FULL) ? ST_ISSUE : ST_HOLD;
                     end
                  end
               end
               ST_HOLD: begin
                  if (level < FULL) state <= ST_ISSUE;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sample       <= '0;
         sample_valid <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         sample_valid <= pop_ok;
         if (pop_ok) sample <= head;
         if (go) underflow <= 1'b0;
         else if (sample_req && level == '0) underflow <= 1'b1;
      end
   end

endmodule
